// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and the 4-bit lookahead primitive for the pipelined CLA adder.
package cla_pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned GROUP_BITS = 4;

    // Carries c[0..4] of one 4-bit group, each expanded directly from bit g/p and c0.
    function automatic logic [GROUP_BITS:0] group_carries(
        input logic [GROUP_BITS-1:0] g,
        input logic [GROUP_BITS-1:0] p,
        input logic                  c0
    );
        logic [GROUP_BITS:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & c0);
        return c;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational STAGE_BITS-wide carry-lookahead slice built from 4-bit groups
// plus a group lookahead unit.
module cla_slice
    import cla_pipe_adder_pkg::*;
#(
    parameter int unsigned STAGE_BITS = 8
) (
    input  logic [STAGE_BITS-1:0] a,
    input  logic [STAGE_BITS-1:0] b_eff,
    input  logic                  c_in,
    output logic [STAGE_BITS-1:0] sum,
    output logic                  c_out,
    output logic                  g_out,
    output logic                  p_out,
    output logic                  c_msb
);

    localparam int unsigned NUM_GROUPS = STAGE_BITS / GROUP_BITS;

    logic [STAGE_BITS-1:0] g_bit;
    logic [STAGE_BITS-1:0] p_bit;
    logic [STAGE_BITS-1:0] c_bit;
    logic [NUM_GROUPS-1:0] g_grp;
    logic [NUM_GROUPS-1:0] p_grp;
    logic [NUM_GROUPS:0]   c_grp;

    always_comb begin
        logic [GROUP_BITS:0] gc;
        logic                run_p;
        g_bit = a & b_eff;
        p_bit = a ^ b_eff;
        g_grp = '0;
        p_grp = '0;
        c_grp = '0;
        c_bit = '0;
        g_out = 1'b0;
        p_out = 1'b1;

        for (int j = 0; j < int'(NUM_GROUPS); j++) begin
            gc       = group_carries(g_bit[j*GROUP_BITS +: GROUP_BITS],
                                     p_bit[j*GROUP_BITS +: GROUP_BITS], 1'b0);
            g_grp[j] = gc[GROUP_BITS];
            p_grp[j] = &p_bit[j*GROUP_BITS +: GROUP_BITS];
        end

        // Each group carry is a flat sum of products over lower groups, not a ripple chain.
        for (int j = 0; j <= int'(NUM_GROUPS); j++) begin
            run_p = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                c_grp[j] = c_grp[j] | (g_grp[i] & run_p);
                run_p    = run_p & p_grp[i];
            end
            c_grp[j] = c_grp[j] | (run_p & c_in);
        end

        for (int i = int'(NUM_GROUPS) - 1; i >= 0; i--) begin
            g_out = g_out | (g_grp[i] & p_out);
            p_out = p_out & p_grp[i];
        end

        for (int j = 0; j < int'(NUM_GROUPS); j++) begin
            gc = group_carries(g_bit[j*GROUP_BITS +: GROUP_BITS],
                               p_bit[j*GROUP_BITS +: GROUP_BITS], c_grp[j]);
            c_bit[j*GROUP_BITS +: GROUP_BITS] = gc[GROUP_BITS-1:0];
        end

        sum   = p_bit ^ c_bit;
        c_out = c_grp[NUM_GROUPS];
        c_msb = c_bit[STAGE_BITS-1];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one STAGE_BITS slice per stage,
// registered inter-stage carry, valid/ready handshake with whole-pipe stall.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned STAGE_BITS = 8,
    parameter int unsigned NUM_STAGES = WIDTH / STAGE_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ofl,
    output logic             zero
);

    if (STAGE_BITS == 0 || (STAGE_BITS % GROUP_BITS) != 0 || (WIDTH % STAGE_BITS) != 0
        || NUM_STAGES != WIDTH / STAGE_BITS) begin : g_bad_params
        $fatal(1, "cla_pipe_adder: illegal WIDTH/STAGE_BITS/NUM_STAGES combination");
    end

    // word_q rotates right each stage: unconsumed A bits at the bottom, finished sum bits enter at the top.
    logic [WIDTH-1:0]      word_q   [NUM_STAGES];
    logic [WIDTH-1:0]      b_q      [NUM_STAGES];
    logic [NUM_STAGES-1:0] carry_q;
    logic [NUM_STAGES-1:0] valid_q;
    logic                  ofl_q;
    logic                  zero_q;

    logic [WIDTH-1:0]      word_in  [NUM_STAGES];
    logic [WIDTH-1:0]      b_in     [NUM_STAGES];
    logic [WIDTH-1:0]      word_nxt [NUM_STAGES];
    logic [STAGE_BITS-1:0] slice_sum[NUM_STAGES];
    logic                  slice_co [NUM_STAGES];
    logic                  slice_cmsb[NUM_STAGES];
    logic [NUM_STAGES-1:0] slice_g;
    logic [NUM_STAGES-1:0] slice_p;
    logic [NUM_STAGES-1:0] cin_s;
    logic [NUM_STAGES-1:0] valid_in;
    logic [NUM_STAGES-1:0] carry_nxt;

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             ofl_nxt;
    logic             zero_nxt;

    assign stall    = valid_q[NUM_STAGES-1] & ~out_ready;
    assign in_ready = ~stall;
    assign b_eff    = (op == OP_SUB) ? ~b : b;
    assign c_eff    = (op == OP_SUB) ? 1'b1 : c_in;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign word_in[k]  = a;
            assign b_in[k]     = b_eff;
            assign cin_s[k]    = c_eff;
            assign valid_in[k] = in_valid;
        end else begin : g_next
            assign word_in[k]  = word_q[k-1];
            assign b_in[k]     = b_q[k-1];
            assign cin_s[k]    = carry_q[k-1];
            assign valid_in[k] = valid_q[k-1];
        end

        cla_slice #(.STAGE_BITS(STAGE_BITS)) u_slice (
            .a     (word_in[k][STAGE_BITS-1:0]),
            .b_eff (b_in[k][STAGE_BITS-1:0]),
            .c_in  (cin_s[k]),
            .sum   (slice_sum[k]),
            .c_out (slice_co[k]),
            .g_out (slice_g[k]),
            .p_out (slice_p[k]),
            .c_msb (slice_cmsb[k])
        );

        assign carry_nxt[k] = slice_g[k] | (slice_p[k] & cin_s[k]);
        assign word_nxt[k]  = (word_in[k] >> STAGE_BITS)
                            | (WIDTH'(slice_sum[k]) << (WIDTH - STAGE_BITS));

        // The slice's own carry-out must agree with its G/P lookahead.
        always_comb begin
            if (!rst) assert (slice_co[k] == carry_nxt[k]);
        end
    end

    assign ofl_nxt  = slice_cmsb[NUM_STAGES-1] ^ carry_nxt[NUM_STAGES-1];
    assign zero_nxt = (word_nxt[NUM_STAGES-1] == '0);

    // Pipeline registers: all hold on stall, data loads only with a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ofl_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                word_q[k] <= '0;
                b_q[k]    <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                valid_q[k] <= valid_in[k];
                if (valid_in[k]) begin
                    word_q[k]  <= word_nxt[k];
                    b_q[k]     <= b_in[k] >> STAGE_BITS;
                    carry_q[k] <= carry_nxt[k];
                end
            end
            if (valid_in[NUM_STAGES-1]) begin
                ofl_q  <= ofl_nxt;
                zero_q <= zero_nxt;
            end
        end
    end

    assign out_valid = valid_q[NUM_STAGES-1];
    assign sum       = word_q[NUM_STAGES-1];
    assign c_out     = carry_q[NUM_STAGES-1];
    assign ofl       = ofl_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed vector table and handshake sequences on a 16/8 adder, plus a
// scoreboarded random stream on a 32/4 adder.
module tb_cla_pipe_adder;
    import cla_pipe_adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, c_in, op, out_valid, out_ready, c_out, ofl, zero;
    logic [15:0] a, b, sum;

    cla_pipe_adder #(.WIDTH(16), .STAGE_BITS(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ofl(ofl), .zero(zero)
    );

    logic        r_in_valid, r_in_ready, r_c_in, r_op, r_out_valid, r_out_ready;
    logic        r_c_out, r_ofl, r_zero;
    logic [31:0] r_a, r_b, r_sum;

    cla_pipe_adder #(.WIDTH(32), .STAGE_BITS(4)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .a(r_a), .b(r_b), .c_in(r_c_in), .op(r_op),
        .out_valid(r_out_valid), .out_ready(r_out_ready),
        .sum(r_sum), .c_out(r_c_out), .ofl(r_ofl), .zero(r_zero)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c_in;
        logic        op;
        logic [15:0] sum;
        logic        c_out;
        logic        ofl;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } rexp_t;

    localparam int NUM_VECS = 12;
    localparam int NUM_RAND = 10000;

    vec_t        vecs[NUM_VECS];
    logic [15:0] stream_exp[4];
    rexp_t       sb_q[$];

    // Reference: plain wide arithmetic, overflow from the true signed result range.
    function automatic rexp_t model(input logic [31:0] x, input logic [31:0] y,
                                    input logic ci, input logic opv);
        rexp_t  r;
        logic [32:0] t;
        longint sres;
        if (opv == OP_SUB) begin
            t    = {1'b0, x} + {1'b0, ~y} + 33'd1;
            sres = longint'($signed(x)) - longint'($signed(y));
        end else begin
            t    = {1'b0, x} + {1'b0, y} + 33'(ci);
            sres = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        r.s = t[31:0];
        r.c = t[32];
        r.o = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        r.z = (t[31:0] == 32'd0);
        return r;
    endfunction

    initial begin
        int    lat;
        bit    got_out;
        int    sent, got, hold_left, cyc;
        bit    seen;
        bit    pending;
        int    bin, bout;
        rexp_t e;

        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, OP_ADD, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h00FF, 16'h0001, 1'b0, OP_ADD, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h0000, 16'h0001, 1'b0, OP_SUB, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0001, 1'b1, OP_SUB, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h0001, 1'b1, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, OP_ADD, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h0005, 16'h0005, 1'b0, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'h8000, 16'h8000, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{16'h80FF, 16'h7F01, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
        stream_exp = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; op = OP_ADD;
        r_in_valid = 1'b0; r_out_ready = 1'b1; r_a = '0; r_b = '0; r_c_in = 1'b0; r_op = OP_ADD;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset sum", 64'(sum), 64'd0);
        chk("reset flags", 64'({c_out, ofl, zero}), 64'd0);
        chk("reset wide out_valid", 64'(r_out_valid), 64'd0);

        // Directed vector table, one beat at a time
        for (int i = 0; i < NUM_VECS; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; c_in = vecs[i].c_in; op = vecs[i].op;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk);
            lat = 0; got_out = 1'b0;
            while (!got_out && lat < 10) begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                got_out = out_valid;
            end
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
            chk($sformatf("vec%0d sum", i), 64'(sum), 64'(vecs[i].sum));
            chk($sformatf("vec%0d c_out", i), 64'(c_out), 64'(vecs[i].c_out));
            chk($sformatf("vec%0d ofl", i), 64'(ofl), 64'(vecs[i].ofl));
            chk($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].zero));
        end

        // Back-to-back stream with a 3-cycle consumer stall once the first result is up
        sent = 0; got = 0; hold_left = 3; cyc = 0;
        op = OP_ADD; c_in = 1'b0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
                #1;
                chk("stall in_ready", 64'(in_ready), 64'd0);
                chk("stall sum held", 64'(sum), 64'h2);
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    chk($sformatf("stream beat%0d", got), 64'(sum), 64'(stream_exp[got]));
                    got++;
                end
            end
            in_valid = (sent < 4);
            a = 16'(sent + 1);
            b = 16'(sent + 1);
            #1;
            if (in_valid && in_ready) sent++;
        end
        chk("stream beats out", 64'(got), 64'd4);
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("stream no extra beat", 64'(seen), 64'd0);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 16'd10; b = 16'd10;
        @(negedge clk);
        a = 16'd20; b = 16'd20;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre-reset out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid reset out_valid", 64'(out_valid), 64'd0);
        chk("mid reset in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("flushed beats never emerge", 64'(seen), 64'd0);

        // Random stream on the 32/4 instance with random source and sink pacing
        pending = 1'b0; bin = 0; bout = 0;
        for (int c = 0; c < 60000 && bout < NUM_RAND; c++) begin
            @(negedge clk);
            r_out_ready = ($urandom_range(3) != 0);
            if (r_out_valid && r_out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("wide spurious beat", 64'(1), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("wide beat%0d", bout), 64'({r_sum, r_c_out, r_ofl, r_zero}),
                        64'({e.s, e.c, e.o, e.z}));
                end
                bout++;
            end
            if (!pending && bin < NUM_RAND && $urandom_range(3) != 0) begin
                r_a = $urandom;
                r_b = $urandom;
                case ($urandom_range(7))
                    0: r_b = r_a;
                    1: r_a = 32'h7FFF_FFFF;
                    2: r_b = 32'hFFFF_FFFF;
                    default: ;
                endcase
                r_c_in  = 1'($urandom_range(1));
                r_op    = 1'($urandom_range(1));
                pending = 1'b1;
            end
            r_in_valid = pending;
            #1;
            if (pending && r_in_ready) begin
                sb_q.push_back(model(r_a, r_b, r_c_in, r_op));
                pending = 1'b0;
                bin++;
            end
        end
        chk("wide beats out", 64'(bout), 64'(NUM_RAND));
        chk("wide scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath (ALU and address adders).
- Splits a WIDTH-bit operation into STAGE_BITS-bit slices, one slice per pipeline stage.
- Each slice is built from 4-bit lookahead groups with group generate/propagate; the carry is registered between stages.
- Adds a valid/ready handshake, add/sub mode, and status flags.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of STAGE_BITS.
- STAGE_BITS, 8, bits resolved per pipeline stage; must be a multiple of 4.
- NUM_STAGES, WIDTH/STAGE_BITS, derived; equals the latency in cycles. Do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  adder accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used for ADD only.
- op  input  1  0 = ADD, 1 = SUB.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of the MSB.
- ofl  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); it takes effect on the rising edge.
- Reset state:
  - all stage valid bits are 0, so out_valid = 0;
  - sum, c_out, ofl and zero are 0;
  - in_ready = 1 in the cycle after reset.
- Operation:
  - ADD: sum = a + b + c_in.
  - SUB: sum = a + ~b + 1; c_in is ignored.
  - c_out is the raw carry of that addition, so for SUB, c_out = 1 means no borrow.
  - ofl = (opA_msb == opB_eff_msb) && (sum_msb != opA_msb), where opB_eff is b for ADD and ~b for SUB.
  - zero is computed from the full final sum.
- Pipeline:
  - Stage k (k = 0..NUM_STAGES-1) resolves bits [k*STAGE_BITS +: STAGE_BITS].
  - Its inputs are the registered carry from stage k-1; stage 0 uses the effective carry-in.
  - Operand bits not yet consumed are skewed forward in registers.
  - Completed sum bits are carried along with the beat.
  - Within a stage, the carry into each 4-bit group comes from group G/P lookahead, not a group-to-group ripple.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+NUM_STAGES-1, i.e. NUM_STAGES cycles from in_valid&in_ready to out_valid. The result registers are the last stage registers.
- Throughput: one beat per cycle when out_ready = 1.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall; it is purely combinational from registered out_valid and from out_ready.
  - A beat is accepted iff in_valid & in_ready.
  - When stall = 1, every stage register holds, including its valid bit.
  - When stall = 0, all stages advance; a non-accepted cycle inserts a bubble (valid 0). Bubbles are not collapsed.
  - Outputs stay stable while out_valid = 1 and out_ready = 0.
  - Beats are never dropped or reordered.
- Simultaneous events:
  - Accept and emit in the same cycle is legal and required at full throughput.
  - in_valid asserted during a stall is ignored; the source must hold its beat.
- Reset mid-operation: all in-flight beats are discarded, and out_valid = 0 after the reset edge regardless of out_ready.
- Degenerate case STAGE_BITS == WIDTH: a single-stage registered adder, latency 1.
- Parameter violations are checked at elaboration; an illegal combination causes a fatal error.

Decomposition:
- Shared package/header:
  - OP_ADD = 1'b0, OP_SUB = 1'b1;
  - GROUP_BITS = 4.
- One sub-module, cla_slice: combinational, STAGE_BITS wide.
  - Inputs: a, b_eff, c_in.
  - Outputs: sum slice, c_out, slice G/P, and carry into the MSB (needed for ofl in the final stage).
  - Internally built from 4-bit lookahead groups and a group lookahead unit.
- Top level: generate loop of NUM_STAGES slices plus the skew/valid registers and handshake logic.

Test Plan:
- Defaults (16/8, latency 2), ADD 0x1234 + 0x4321, c_in = 0 -> 2 cycles later sum = 0x5555, c_out = 0, ofl = 0, zero = 0.
- ADD 0x00FF + 0x0001 -> 0x0100 (carry crosses the stage boundary); ADD 0xFFFF + 0x0001 -> sum = 0x0000, c_out = 1, zero = 1; ADD 0x7FFF + 0x0001 -> 0x8000, ofl = 1, c_out = 0.
- SUB 0x0000 - 0x0001 -> sum = 0xFFFF, c_out = 0, ofl = 0; SUB 0x8000 - 0x0001 -> 0x7FFF, ofl = 1, c_out = 1; SUB with c_in = 1 gives the same results (c_in ignored).
- Stream 4 beats (1+1, 2+2, 3+3, 4+4) back to back and hold out_ready = 0 for 3 cycles once out_valid rises -> in_ready = 0 during the hold, sum held at 0x0002, then outputs 2, 4, 6, 8 in order with no loss.
- Assert rst for one cycle with 2 beats in flight -> out_valid = 0 next cycle, in_ready = 1, neither beat ever emerges.
- Random regression at WIDTH = 32, STAGE_BITS = 4 (latency 8) with random in_valid/out_ready -> scoreboard matches a + b + c_in and a - b, plus c_out/ofl/zero, for ≥10k beats.
